// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with request/valid instruction fetch and branch target resolution
// Define PC_FETCH_PERF_CNT_EN to add saturating RETIRED_CNT/TAKEN_CNT outputs.
module pc_fetch_unit #(
    parameter int PC_W = 32,
    parameter int OFF_W = 8,
    parameter int INSTR_W = 32,
    parameter int INSTR_BYTES = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic               IMEM_REQ,
    output logic [PC_W-1:0]    IMEM_ADDR,
    input  logic               IMEM_VALID,
    input  logic [INSTR_W-1:0] IMEM_DATA,
    output logic [INSTR_W-1:0] INSTR,
    output logic               INSTR_VALID,
    output logic [PC_W-1:0]    PC,
    input  logic               HOLD,
    input  logic [1:0]         BR_TYPE,
    input  logic               BR_ZERO,
    input  logic [OFF_W-1:0]   BR_OFFSET
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   RETIRED_CNT,
    output logic [CNT_W-1:0]   TAKEN_CNT
`endif
);
    localparam int SH = $clog2(INSTR_BYTES);
    localparam logic [PC_W-1:0] LOW = PC_W'(INSTR_BYTES - 1);

    typedef enum logic {FETCH, ISSUE} state_t;
    state_t state;

    logic taken, retire;
    logic [PC_W-1:0] seq_pc, tgt_pc;

    // 01 jump, 10 BEQ (zero), 11 BNE (not zero), 00 never
    assign taken = BR_TYPE[1] ? (BR_ZERO ^ BR_TYPE[0]) : BR_TYPE[0];
    assign retire = state == ISSUE && !HOLD;
    assign seq_pc = PC + PC_W'(INSTR_BYTES);
    assign tgt_pc = seq_pc + (PC_W'($signed(BR_OFFSET)) << SH);
    assign IMEM_REQ = state == FETCH;
    assign IMEM_ADDR = PC;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FETCH;
            PC <= RESET_PC & ~LOW;
            INSTR <= '0;
            INSTR_VALID <= 1'b0;
        end else if (state == FETCH && IMEM_VALID) begin
            INSTR <= IMEM_DATA;
            INSTR_VALID <= 1'b1;
            state <= ISSUE;
        end else if (retire) begin
            PC <= taken ? tgt_pc : seq_pc;
            INSTR_VALID <= 1'b0;
            state <= FETCH;
        end
    end

`ifdef PC_FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RETIRED_CNT <= '0;
            TAKEN_CNT <= '0;
        end else if (retire) begin
            if (!(&RETIRED_CNT)) RETIRED_CNT <= RETIRED_CNT + CNT_W'(1);
            if (taken && !(&TAKEN_CNT)) TAKEN_CNT <= TAKEN_CNT + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for fetch handshake, branch targets, hold, reset and wrap.
module tb_pc_fetch_unit;
    logic        CLK, RESET, IMEM_REQ, IMEM_VALID, INSTR_VALID, HOLD, BR_ZERO;
    logic [31:0] IMEM_ADDR, IMEM_DATA, INSTR, PC;
    logic [1:0]  BR_TYPE;
    logic [7:0]  BR_OFFSET;
    int errs = 0, checks = 0;
`ifdef PC_FETCH_PERF_CNT_EN
    logic [3:0] RETIRED_CNT, TAKEN_CNT;
    int ret_m = 0, tk_m = 0;
`endif

    pc_fetch_unit #(.PC_W(32), .OFF_W(8), .INSTR_W(32), .INSTR_BYTES(4), .RESET_PC(32'h0), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_VALID(IMEM_VALID), .IMEM_DATA(IMEM_DATA), .INSTR(INSTR),
        .INSTR_VALID(INSTR_VALID), .PC(PC), .HOLD(HOLD), .BR_TYPE(BR_TYPE),
        .BR_ZERO(BR_ZERO), .BR_OFFSET(BR_OFFSET)
`ifdef PC_FETCH_PERF_CNT_EN
        , .RETIRED_CNT(RETIRED_CNT), .TAKEN_CNT(TAKEN_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  t;
        logic        z;
        logic [7:0]  off;
        logic [31:0] pc;
        logic [31:0] nxt;
    } vec_t;
    vec_t v[15];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1234_A5A5 ^ {a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_cnt;
`ifdef PC_FETCH_PERF_CNT_EN
        chk("retired_cnt", RETIRED_CNT, ret_m);
        chk("taken_cnt", TAKEN_CNT, tk_m);
`endif
    endtask

    // Memory answers after `waits` idle cycles; address must hold steady meanwhile.
    task automatic fetch(input int waits, input logic [31:0] exp_pc);
        chk("fetch_req", IMEM_REQ, 1);
        chk("fetch_addr", IMEM_ADDR, exp_pc);
        chk("fetch_valid_low", INSTR_VALID, 0);
        for (int i = 0; i < waits; i++) begin
            tick;
            chk("wait_req", IMEM_REQ, 1);
            chk("wait_addr", IMEM_ADDR, exp_pc);
        end
        IMEM_VALID = 1'b1;
        IMEM_DATA = mem(exp_pc);
        tick;
        IMEM_VALID = 1'b0;
        IMEM_DATA = 32'hBAD0_BAD0;
        chk("issue_valid", INSTR_VALID, 1);
        chk("issue_instr", INSTR, mem(exp_pc));
        chk("issue_pc", PC, exp_pc);
        chk("issue_req", IMEM_REQ, 0);
    endtask

    task automatic issue(input logic [1:0] t, input logic z, input logic [7:0] off);
        BR_TYPE = t;
        BR_ZERO = z;
        BR_OFFSET = off;
        HOLD = 1'b0;
        tick;
        BR_TYPE = 2'b00;
        BR_ZERO = 1'b0;
        BR_OFFSET = 8'h00;
        chk("exit_valid", INSTR_VALID, 0);
        chk("exit_req", IMEM_REQ, 1);
`ifdef PC_FETCH_PERF_CNT_EN
        if (ret_m < 15) ret_m++;
        if ((t == 2'b01 || (t == 2'b10 && z) || (t == 2'b11 && !z)) && tk_m < 15) tk_m++;
`endif
        chk_cnt();
    endtask

    initial begin
        logic [31:0] pc;
        v[0]  = '{2'b00, 1'b0, 8'h00, 32'h00, 32'h04};
        v[1]  = '{2'b00, 1'b1, 8'h05, 32'h04, 32'h08};
        v[2]  = '{2'b00, 1'b0, 8'h00, 32'h08, 32'h0C};
        v[3]  = '{2'b00, 1'b0, 8'h00, 32'h0C, 32'h10};
        v[4]  = '{2'b01, 1'b0, 8'hFE, 32'h10, 32'h0C};
        v[5]  = '{2'b01, 1'b1, 8'h03, 32'h0C, 32'h1C};
        v[6]  = '{2'b00, 1'b0, 8'h00, 32'h1C, 32'h20};
        v[7]  = '{2'b10, 1'b1, 8'h02, 32'h20, 32'h2C};
        v[8]  = '{2'b01, 1'b0, 8'hFC, 32'h2C, 32'h20};
        v[9]  = '{2'b10, 1'b0, 8'h02, 32'h20, 32'h24};
        v[10] = '{2'b01, 1'b0, 8'hFE, 32'h24, 32'h20};
        v[11] = '{2'b11, 1'b0, 8'h02, 32'h20, 32'h2C};
        v[12] = '{2'b01, 1'b1, 8'hFC, 32'h2C, 32'h20};
        v[13] = '{2'b11, 1'b1, 8'h02, 32'h20, 32'h24};
        v[14] = '{2'b00, 1'b1, 8'h7F, 32'h24, 32'h28};

        RESET = 1'b1;
        IMEM_VALID = 1'b0;
        IMEM_DATA = '0;
        HOLD = 1'b0;
        BR_TYPE = 2'b00;
        BR_ZERO = 1'b0;
        BR_OFFSET = 8'h00;
        tick;
        tick;
        chk("rst_req", IMEM_REQ, 1);
        chk("rst_addr", IMEM_ADDR, 0);
        chk("rst_pc", PC, 0);
        chk("rst_instr", INSTR, 0);
        chk("rst_valid", INSTR_VALID, 0);
        chk_cnt();
        RESET = 1'b0;

        for (int i = 0; i < 15; i++) begin
            fetch(0, v[i].pc);
            issue(v[i].t, v[i].z, v[i].off);
            chk("next_pc", IMEM_ADDR, v[i].nxt);
        end

        // Slow memory, then a two-cycle hold with noisy branch inputs and a stray IMEM_VALID
        fetch(3, 32'h28);
        HOLD = 1'b1;
        IMEM_VALID = 1'b1;
        IMEM_DATA = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            BR_TYPE = (i == 0) ? 2'b01 : 2'b11;
            BR_OFFSET = 8'h10;
            tick;
            chk("hold_valid", INSTR_VALID, 1);
            chk("hold_pc", PC, 32'h28);
            chk("hold_instr", INSTR, mem(32'h28));
            chk("hold_req", IMEM_REQ, 0);
            chk_cnt();
        end
        IMEM_VALID = 1'b0;
        issue(2'b00, 1'b0, 8'h00);
        chk("after_hold_pc", IMEM_ADDR, 32'h2C);

        // Reset lands on the same edge as a memory return
        RESET = 1'b1;
        IMEM_VALID = 1'b1;
        IMEM_DATA = mem(32'h2C);
        tick;
        RESET = 1'b0;
        IMEM_VALID = 1'b0;
`ifdef PC_FETCH_PERF_CNT_EN
        ret_m = 0;
        tk_m = 0;
`endif
        chk("midrst_instr", INSTR, 0);
        chk("midrst_pc", PC, 0);
        chk("midrst_valid", INSTR_VALID, 0);
        chk("midrst_req", IMEM_REQ, 1);
        chk("midrst_addr", IMEM_ADDR, 0);
        chk_cnt();
        fetch(1, 32'h0);

        // Jump back from 0 wraps to the top, then sequential wraps to 0
        issue(2'b01, 1'b0, 8'hFE);
        chk("wrap_jump", IMEM_ADDR, 32'hFFFF_FFFC);
        fetch(0, 32'hFFFF_FFFC);
        issue(2'b00, 1'b0, 8'h00);
        chk("wrap_seq", IMEM_ADDR, 32'h0);

        pc = 32'h0;
        for (int i = 0; i < 18; i++) begin
            fetch(0, pc);
            issue(2'b00, 1'b0, 8'h00);
            pc = pc + 32'h4;
            chk("run_pc", IMEM_ADDR, pc);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
